// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard sequencer for the 5-stage pipeline. It drives the stage
//               enables and flushes for load-use stalls, taken branches and
//               multi-cycle data-memory waits. It also provides the EX operand
//               forwarding selects, a saturating stall-cycle counter and a
//               sticky memory-timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int STALL_CNT_W = 16,
  parameter int TMO_W       = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rt,
  input  logic                   id_ex_MemRead,
  input  logic [4:0]             id_ex_rt,
  input  logic [4:0]             ex_rs,
  input  logic [4:0]             ex_rt,
  input  logic                   ex_mem_RegWrite,
  input  logic [4:0]             ex_mem_rd,
  input  logic                   mem_wb_RegWrite,
  input  logic [4:0]             mem_wb_rd,
  input  logic                   dm_req,
  input  logic                   dm_ready,
  input  logic                   branch_taken,
  output logic                   pc_en,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_en,
  output logic                   mem_wb_en,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_count,
  output logic                   mem_err,
  output logic [1:0]             state
);

  localparam logic [1:0]       c_RUN        = 2'b00;
  localparam logic [1:0]       c_LOAD_STALL = 2'b01;
  localparam logic [1:0]       c_MEM_WAIT   = 2'b10;
  localparam logic [TMO_W-1:0] c_TIMEOUT    = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] c_WAIT_ONE   = TMO_W'(1);

  logic [1:0]             r_state;
  logic [TMO_W-1:0]       r_wait_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   r_mem_err;

  logic [1:0]       w_next_state;
  logic [TMO_W-1:0] w_wait_cnt_nxt;
  logic             w_set_err;
  logic             w_mem_block;
  logic             w_load_use;
  logic             w_pc_en;
  logic             w_if_id_en;
  logic             w_ex_mem_en;
  logic             w_mem_wb_en;
  logic             w_if_id_flush;
  logic             w_id_ex_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  assign w_mem_block = dm_req & ~dm_ready;
  // A load in EX whose destination (never r0) feeds a source of the ID instruction.
  assign w_load_use  = id_ex_MemRead && (id_ex_rt != 5'd0) &&
                       ((id_ex_rt == id_rs) || (id_uses_rt && (id_ex_rt == id_rt)));

  // Mealy control: memory wait beats branch flush, which beats load-use.
  always_comb begin
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_ex_mem_en    = 1'b1;
    w_mem_wb_en    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_next_state   = c_RUN;
    w_wait_cnt_nxt = '0;
    w_set_err      = 1'b0;
    if (r_state == c_MEM_WAIT) begin
      // Frozen stages still hold their instructions, so branch and load-use
      // are evaluated again after release instead of here.
      if (dm_ready) begin
        w_next_state = c_RUN;
      end else if (r_wait_cnt >= c_TIMEOUT) begin
        w_set_err    = 1'b1;
        w_next_state = c_RUN;
      end else begin
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_en    = 1'b0;
        w_next_state   = c_MEM_WAIT;
        w_wait_cnt_nxt = r_wait_cnt + c_WAIT_ONE;
      end
    end else begin
      if (w_mem_block) begin
        w_pc_en        = 1'b0;
        w_if_id_en     = 1'b0;
        w_ex_mem_en    = 1'b0;
        w_mem_wb_en    = 1'b0;
        w_next_state   = c_MEM_WAIT;
        w_wait_cnt_nxt = c_WAIT_ONE;
      end else if (branch_taken) begin
        w_if_id_flush = 1'b1;
        w_id_ex_flush = 1'b1;
      end else if ((r_state != c_LOAD_STALL) && w_load_use) begin
        // The bubble cycle itself must not re-detect the same load.
        w_pc_en       = 1'b0;
        w_if_id_en    = 1'b0;
        w_id_ex_flush = 1'b1;
        w_next_state  = c_LOAD_STALL;
      end
    end
  end

  // Forwarding selects: the younger EX_MEM result takes precedence over MEM_WB.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (ex_mem_RegWrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == ex_rs))
      w_fwd_a = 2'b10;
    else if (mem_wb_RegWrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == ex_rs))
      w_fwd_a = 2'b01;
    if (ex_mem_RegWrite && (ex_mem_rd != 5'd0) && (ex_mem_rd == ex_rt))
      w_fwd_b = 2'b10;
    else if (mem_wb_RegWrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == ex_rt))
      w_fwd_b = 2'b01;
  end

  // State, wait counter, sticky error and saturating stall counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= c_RUN;
      r_wait_cnt  <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_set_err)
        r_mem_err <= 1'b1;
      if (!w_pc_en && (r_stall_cnt != {STALL_CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Everything quiet while reset is held, independent of the clock.
  assign pc_en       = reset & w_pc_en;
  assign if_id_en    = reset & w_if_id_en;
  assign ex_mem_en   = reset & w_ex_mem_en;
  assign mem_wb_en   = reset & w_mem_wb_en;
  assign if_id_flush = reset & w_if_id_flush;
  assign id_ex_flush = reset & w_id_ex_flush;
  assign fwd_a       = reset ? w_fwd_a : 2'b00;
  assign fwd_b       = reset ? w_fwd_b : 2'b00;
  assign stall_count = r_stall_cnt;
  assign mem_err     = r_mem_err;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl. It runs directed
//               scenarios and random stimulus against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_ex_rt = '0, ex_rs = '0, ex_rt = '0;
  logic [4:0]  ex_mem_rd = '0, mem_wb_rd = '0;
  logic        id_uses_rt = 1'b0, id_ex_MemRead = 1'b0;
  logic        ex_mem_RegWrite = 1'b0, mem_wb_RegWrite = 1'b0;
  logic        dm_req = 1'b0, dm_ready = 1'b0, branch_taken = 1'b0;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [15:0] stall_count;
  logic        mem_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: pipeline situation, not register encoding.
  int m_mode;     // 0 normal flow, 1 just inserted a load bubble, 2 waiting on memory
  int m_waited;   // frozen cycles spent on the current memory access
  int m_stalls;
  bit m_err;

  pipeline_hazard_ctrl #(.STALL_CNT_W(16), .TMO_W(8), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_MemRead(id_ex_MemRead), .id_ex_rt(id_ex_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_RegWrite(ex_mem_RegWrite), .ex_mem_rd(ex_mem_rd),
    .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_rd(mem_wb_rd),
    .dm_req(dm_req), .dm_ready(dm_ready), .branch_taken(branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count),
    .mem_err(mem_err), .state(state)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (ex_mem_RegWrite && ex_mem_rd != 0 && ex_mem_rd == src) return 2'b10;
    if (mem_wb_RegWrite && mem_wb_rd != 0 && mem_wb_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_stalls = 0; m_err = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_pc_en"}, 32'(pc_en), 0);
    check_val({tag, "_if_id_en"}, 32'(if_id_en), 0);
    check_val({tag, "_ex_mem_en"}, 32'(ex_mem_en), 0);
    check_val({tag, "_mem_wb_en"}, 32'(mem_wb_en), 0);
    check_val({tag, "_flushes"}, 32'({if_id_flush, id_ex_flush}), 0);
    check_val({tag, "_fwd"}, 32'({fwd_a, fwd_b}), 0);
    check_val({tag, "_state"}, 32'(state), 0);
    check_val({tag, "_stall_count"}, 32'(stall_count), 0);
    check_val({tag, "_mem_err"}, 32'(mem_err), 0);
  endtask

  // Inputs are already driven; check one cycle against the model and advance it.
  task automatic step();
    bit hazard, blocked, timed_out, released;
    bit e_pc, e_ifid, e_exmem, e_memwb, e_fl_ifid, e_fl_idex;
    #3;
    hazard  = id_ex_MemRead && id_ex_rt != 0 &&
              (id_ex_rt == id_rs || (id_uses_rt && id_ex_rt == id_rt));
    blocked = dm_req && !dm_ready;
    timed_out = 0; released = 0;
    {e_pc, e_ifid, e_exmem, e_memwb, e_fl_ifid, e_fl_idex} = 6'b111100;
    if (m_mode == 2) begin
      timed_out = !dm_ready && m_waited >= MEM_TIMEOUT;
      released  = dm_ready || timed_out;
      if (!released) {e_pc, e_ifid, e_exmem, e_memwb} = 4'b0000;
    end else if (blocked) begin
      {e_pc, e_ifid, e_exmem, e_memwb} = 4'b0000;
    end else if (branch_taken) begin
      {e_fl_ifid, e_fl_idex} = 2'b11;
    end else if (m_mode == 0 && hazard) begin
      e_pc = 0; e_ifid = 0; e_fl_idex = 1;
    end
    check_val("pc_en", 32'(pc_en), 32'(e_pc));
    check_val("if_id_en", 32'(if_id_en), 32'(e_ifid));
    check_val("ex_mem_en", 32'(ex_mem_en), 32'(e_exmem));
    check_val("mem_wb_en", 32'(mem_wb_en), 32'(e_memwb));
    check_val("if_id_flush", 32'(if_id_flush), 32'(e_fl_ifid));
    check_val("id_ex_flush", 32'(id_ex_flush), 32'(e_fl_idex));
    check_val("fwd_a", 32'(fwd_a), 32'(fwd_sel(ex_rs)));
    check_val("fwd_b", 32'(fwd_b), 32'(fwd_sel(ex_rt)));
    check_val("state", 32'(state), 32'(m_mode));
    check_val("stall_count", 32'(stall_count), 32'(m_stalls));
    check_val("mem_err", 32'(mem_err), 32'(m_err));
    @(posedge clock);
    if (m_mode == 2) begin
      if (released) begin
        if (timed_out) m_err = 1;
        m_mode = 0; m_waited = 0;
      end else m_waited++;
    end else if (blocked) begin
      m_mode = 2; m_waited = 1;
    end else if (branch_taken) m_mode = 0;
    else if (m_mode == 0 && hazard) m_mode = 1;
    else m_mode = 0;
    if (!e_pc && m_stalls < 65535) m_stalls++;
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_ex_MemRead = 0; id_ex_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_mem_RegWrite = 0; ex_mem_rd = 0;
    mem_wb_RegWrite = 0; mem_wb_rd = 0; dm_req = 0; dm_ready = 0; branch_taken = 0;
  endtask

  initial begin
    model_reset();
    // Reset held with forwarding matches present: outputs must stay quiet.
    ex_mem_RegWrite = 1; ex_mem_rd = 3; ex_rs = 3; ex_rt = 3;
    #12;
    check_reset_outputs("por");
    @(posedge clock); #1;
    reset = 1;
    idle_inputs();

    // Quiet running.
    repeat (10) step();

    // Load-use on rs, then the bubble cycle, then normal flow.
    id_ex_MemRead = 1; id_ex_rt = 5; id_rs = 5;
    step();
    step();                       // bubble cycle: hazard inputs still present
    idle_inputs();
    step();
    check_val("lu_stall_count", 32'(stall_count), 1);

    // Forwarding priority and r0 exclusion.
    ex_mem_RegWrite = 1; mem_wb_RegWrite = 1; ex_mem_rd = 3; mem_wb_rd = 3;
    ex_rs = 3; ex_rt = 3;
    step();
    ex_mem_rd = 0; step();
    mem_wb_rd = 0; step();
    idle_inputs();

    // Four-cycle memory wait with a pending branch, released on ready.
    dm_req = 1; dm_ready = 0; branch_taken = 1;
    repeat (4) step();
    dm_ready = 1; step();
    dm_req = 0; dm_ready = 0; step();   // branch now flushes
    idle_inputs();
    check_val("mw_stall_count", 32'(stall_count), 5);

    // Timeout: memory never answers.
    dm_req = 1; dm_ready = 0;
    repeat (MEM_TIMEOUT + 1) step();
    check_val("tmo_mem_err", 32'(mem_err), 1);
    idle_inputs();
    repeat (3) step();
    check_val("tmo_sticky", 32'(mem_err), 1);

    // Random traffic over a small register set to provoke matches.
    for (int i = 0; i < 2000; i++) begin
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom); id_ex_MemRead = ($urandom % 3) == 0;
      id_ex_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3)); ex_rt = 5'($urandom_range(0, 3));
      ex_mem_RegWrite = 1'($urandom); ex_mem_rd = 5'($urandom_range(0, 3));
      mem_wb_RegWrite = 1'($urandom); mem_wb_rd = 5'($urandom_range(0, 3));
      dm_req = ($urandom % 4) == 0; dm_ready = ($urandom % 3) != 0;
      branch_taken = ($urandom % 5) == 0;
      step();
    end

    // Reset asserted in the middle of a memory wait.
    idle_inputs();
    dm_req = 1; dm_ready = 0;
    repeat (3) step();
    #2 reset = 0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge clock); #1;
    reset = 1;
    model_reset();
    idle_inputs();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
